// File: rtl/seg_display_mux.sv
// Time-multiplexed common-anode 7-segment driver with hex/decimal display, sequential
// binary-to-BCD conversion, leading-zero blanking, per-digit decimal points and PWM brightness.
module seg_display_mux #(
    parameter int DIGITS     = 4,
    parameter int BIN_W      = 14,
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BIN_W-1:0]  value,
    input  logic              mode,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp,
    input  logic [3:0]        brightness,
    output logic              busy,
    output logic [6:0]        seg,
    output logic              dp_out,
    output logic [DIGITS-1:0] an
);

    localparam int SUB_RAW = CLK_HZ / (REFRESH_HZ * DIGITS * 16);
    localparam int SUB     = (SUB_RAW < 1) ? 1 : SUB_RAW;
    localparam int PRE_W   = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W   = $clog2(BIN_W + 1);
    localparam int BCD_W   = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t state_reg, state_next;

    // conversion datapath
    logic [BIN_W-1:0] bin_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic [BCD_W-1:0] bcd_adj;
    logic             ovf_reg;
    logic [CNT_W-1:0] cnt_reg;

    // shown digits
    logic [3:0]       digit_reg [DIGITS];
    logic             dash_reg;
    logic [BCD_W-1:0] hex_ext;
    logic [DIGITS-1:0] blank_vec;
    logic             nz_run;

    // scan state
    logic [PRE_W-1:0] pre_reg;
    logic [3:0]       phase_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             sub_tick;

    // drive stage (active-high form before polarity)
    logic [3:0]        cur_digit;
    logic              slot_on;
    logic [6:0]        seg_hi;
    logic [DIGITS-1:0] an_hi;
    logic              dp_hi;

    logic load_hex;
    logic load_dec;

    assign load_hex = (state_reg == S_IDLE) && load && !mode;
    assign load_dec = (state_reg == S_IDLE) && load && mode;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy      <= (state_next != S_IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (load_dec) state_next = S_CONV;
            S_CONV:   if (cnt_reg == CNT_W'(BIN_W - 1)) state_next = S_COMMIT;
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add-3: correct every BCD digit >= 5 before the shift
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 :
                                        bcd_reg[4*gi +: 4];
        end
    endgenerate

    // Any bit shifted out of the top digit means the value needs more digits than we have.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg <= '0;
            bcd_reg <= '0;
            ovf_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (load_dec) begin
            bin_reg <= value;
            bcd_reg <= '0;
            ovf_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (state_reg == S_CONV) begin
            bcd_reg <= {bcd_adj[BCD_W-2:0], bin_reg[BIN_W-1]};
            bin_reg <= bin_reg << 1;
            ovf_reg <= ovf_reg | bcd_adj[BCD_W-1];
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Shown digits: hex loads update directly, decimal loads only at COMMIT
    // ------------------------------------------------------------------
    assign hex_ext = BCD_W'(value);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) digit_reg[i] <= 4'd0;
            dash_reg <= 1'b0;
        end else if (load_hex) begin
            for (int i = 0; i < DIGITS; i++) digit_reg[i] <= hex_ext[4*i +: 4];
            dash_reg <= 1'b0;
        end else if (state_reg == S_COMMIT) begin
            for (int i = 0; i < DIGITS; i++) digit_reg[i] <= bcd_reg[4*i +: 4];
            dash_reg <= ovf_reg;
        end
    end

    // Walk from the most significant digit down, tracking whether a non-zero digit was seen.
    always_comb begin
        blank_vec = '0;
        nz_run    = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_run       = nz_run | (|digit_reg[i]);
            blank_vec[i] = (i != 0) && blank_lz && !dash_reg && !nz_run;
        end
    end

    // ------------------------------------------------------------------
    // Scan: prescaler -> 16-step PWM phase -> digit index
    // ------------------------------------------------------------------
    assign sub_tick = (pre_reg == PRE_W'(SUB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg   <= '0;
            phase_reg <= 4'd0;
            idx_reg   <= '0;
        end else begin
            pre_reg <= sub_tick ? '0 : pre_reg + PRE_W'(1);
            if (sub_tick) begin
                phase_reg <= phase_reg + 4'd1;
                if (phase_reg == 4'd15) begin
                    idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Glyphs and output drive
    // ------------------------------------------------------------------
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    always_comb begin
        cur_digit = digit_reg[idx_reg];
        slot_on   = (phase_reg < brightness);
        if (dash_reg) begin
            seg_hi = 7'h40;
        end else if (blank_vec[idx_reg]) begin
            seg_hi = 7'h00;
        end else begin
            seg_hi = glyph(cur_digit);
        end
        an_hi = slot_on ? (DIGITS'(1) << idx_reg) : '0;
        dp_hi = slot_on & dp[idx_reg];
    end

    // Polarity is folded in only here so everything upstream stays active-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg    <= {7{ACTIVE_LOW}};
            an     <= {DIGITS{ACTIVE_LOW}};
            dp_out <= ACTIVE_LOW;
        end else begin
            seg    <= seg_hi ^ {7{ACTIVE_LOW}};
            an     <= an_hi ^ {DIGITS{ACTIVE_LOW}};
            dp_out <= dp_hi ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: a value-level display model checked every cycle,
// plus literal frame expectations for the hex, decimal, overflow, blanking, brightness and dp cases.
module tb_seg_display_mux;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load = 1'b0;
    logic [BIN_W-1:0]  value = '0;
    logic              mode = 1'b0;
    logic              blank_lz = 1'b0;
    logic [DIGITS-1:0] dp = '0;
    logic [3:0]        brightness = 4'd15;
    logic              busy;
    logic [6:0]        seg;
    logic              dp_out;
    logic [DIGITS-1:0] an;

    int n_vec = 0;
    int n_err = 0;

    seg_display_mux #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .CLK_HZ(1600), .REFRESH_HZ(25), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .mode(mode),
        .blank_lz(blank_lz), .dp(dp), .brightness(brightness),
        .busy(busy), .seg(seg), .dp_out(dp_out), .an(an)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp_v);
        end
    endtask

    // Model: the shown number as an integer plus a pending decimal result and a scan position.
    int         m_val = 0, m_pend = 0, m_left = 0, m_pos = 0;
    bit         m_dec = 0;
    int         m_idx, m_ph, m_base, m_pw, m_digit;
    bit         m_on, m_dash, m_blank;
    logic [6:0] m_hi;
    logic [3:0] e_an = 4'hF;
    logic [6:0] e_seg = 7'h7F;
    logic       e_dp = 1'b1;
    logic       e_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val = 0; m_pend = 0; m_left = 0; m_pos = 0; m_dec = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_busy = 1'b0;
        end else begin
            m_idx  = (m_pos / 16) % DIGITS;
            m_ph   = m_pos % 16;
            m_on   = (m_ph < int'(brightness));
            m_dash = m_dec && (m_val >= 10 ** DIGITS);
            m_base = m_dec ? 10 : 16;
            m_pw   = 1;
            for (int k = 0; k < m_idx; k++) m_pw = m_pw * m_base;
            m_digit = (m_val / m_pw) % m_base;
            m_blank = blank_lz && (m_idx > 0) && !m_dash && (m_val < m_pw);
            if (m_dash)       m_hi = 7'h40;
            else if (m_blank) m_hi = 7'h00;
            else              m_hi = glyph_tab[m_digit];
            e_seg = ~m_hi;
            e_an  = m_on ? ~(4'b0001 << m_idx) : 4'hF;
            e_dp  = !(m_on && dp[m_idx]);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_val = m_pend;
                    m_dec = 1;
                end
            end else if (load) begin
                if (mode) begin
                    m_pend = int'(value);
                    m_left = BIN_W + 1;
                end else begin
                    m_val = int'(value);
                    m_dec = 0;
                end
            end
            e_busy = (m_left > 0);
            m_pos  = (m_pos + 1) % (16 * DIGITS);
        end
    end

    always @(posedge clk) begin
        #1;
        chk("busy", busy, e_busy);
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("dp_out", dp_out, e_dp);
    end

    // Frame statistics over any 64 consecutive cycles (each scan position seen once).
    int         f_cnt_an [DIGITS];
    int         f_idle, f_dp_low, f_dp_low_an2;
    logic [6:0] f_seg [DIGITS];

    task automatic run_frame();
        for (int i = 0; i < DIGITS; i++) begin
            f_cnt_an[i] = 0;
            f_seg[i] = 7'h00;
        end
        f_idle = 0; f_dp_low = 0; f_dp_low_an2 = 0;
        repeat (2) @(posedge clk);
        for (int c = 0; c < 16 * DIGITS; c++) begin
            @(posedge clk);
            #1;
            if (an == 4'hF) f_idle++;
            for (int i = 0; i < DIGITS; i++) begin
                if (an == ~(4'b0001 << i)) begin
                    f_cnt_an[i]++;
                    f_seg[i] = seg;
                end
            end
            if (!dp_out) begin
                f_dp_low++;
                if (an == 4'b1011) f_dp_low_an2++;
            end
        end
    endtask

    task automatic load_val(input int v, input logic m);
        @(negedge clk);
        value = BIN_W'(v);
        mode  = m;
        load  = 1'b1;
        $display("load value=%0d mode=%0d blank_lz=%0d brightness=%0d", v, m, blank_lz, brightness);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        chk("busy_timeout", busy, 1'b0);
    endtask

    task automatic chk_segs(input string name, input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0);
        chk({name, "_d3"}, f_seg[3], s3);
        chk({name, "_d2"}, f_seg[2], s2);
        chk({name, "_d1"}, f_seg[1], s1);
        chk({name, "_d0"}, f_seg[0], s0);
    endtask

    int busy_cnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp_out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hex 2345 at full brightness
        load_val(14'h2345, 1'b0);
        run_frame();
        for (int i = 0; i < DIGITS; i++) chk("hex_slot_len", f_cnt_an[i], 15);
        chk("hex_idle_len", f_idle, 4);
        chk_segs("hex", 7'h24, 7'h30, 7'h19, 7'h12);

        // Brightness 0 and 8
        brightness = 4'd0;
        run_frame();
        chk("dark_idle", f_idle, 64);
        brightness = 4'd8;
        run_frame();
        for (int i = 0; i < DIGITS; i++) chk("half_slot_len", f_cnt_an[i], 8);
        chk("half_idle", f_idle, 32);
        brightness = 4'd15;

        // Decimal 2345 replacing a different hex value
        load_val(14'h0BEE, 1'b0);
        load_val(2345, 1'b1);
        busy_cnt = busy ? 1 : 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
        end
        chk("busy_len", busy_cnt, 15);
        run_frame();
        chk_segs("dec", 7'h24, 7'h30, 7'h19, 7'h12);

        // Overflow dashes, then blanked 7
        load_val(10000, 1'b1);
        wait_idle();
        run_frame();
        chk_segs("ovf", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        blank_lz = 1'b1;
        load_val(7, 1'b1);
        wait_idle();
        run_frame();
        chk_segs("blank", 7'h7F, 7'h7F, 7'h7F, 7'h78);
        blank_lz = 1'b0;

        // Load while busy is dropped
        load_val(9999, 1'b1);
        @(negedge clk);
        @(negedge clk);
        load_val(1234, 1'b1);
        wait_idle();
        run_frame();
        chk_segs("drop", 7'h10, 7'h10, 7'h10, 7'h10);

        // Reset mid-conversion
        load_val(4321, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_an", an, 4'hF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame();
        chk_segs("zeros", 7'h40, 7'h40, 7'h40, 7'h40);

        // Decimal point on digit 2 only
        dp = 4'b0100;
        run_frame();
        chk("dp_low_total", f_dp_low, 15);
        chk("dp_low_in_slot2", f_dp_low_an2, 15);
        dp = 4'b0000;

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
